// File: rtl/conv_pkg.sv
// Shared definitions for the convolution bank controller and its phase sequencer.
package conv_pkg;

  // Phase codes as seen on {eop,sop}; IDLE keeps every bank write enable off.
  typedef enum logic [1:0] {
    PH_LOAD = 2'b00,
    PH_PROC = 2'b01,
    PH_OUT  = 2'b10,
    PH_IDLE = 2'b11
  } phase_e;

  localparam int DEF_N    = 2;
  localparam int DEF_ROWS = 16;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  // Bits needed to hold 0..maxVal, never less than one.
  function automatic int cntWidth(input int maxVal);
    int w;
    w = clog2(maxVal + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/conv_wrap_cnt.sv
// Modulo counter 0..MAX with enable, synchronous clear and a wrap flag.
module conv_wrap_cnt #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == WIDTH'(MAX));
  assign cnt_o  = cnt_q;

  // Clear wins over counting; an enabled count at MAX rolls back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register, zeroed while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/conv_phase_seq.sv
// LOAD -> PROC -> OUT frame sequencer driving the bank controller phase inputs.
module conv_phase_seq
  import conv_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int ROWS        = DEF_ROWS,
  parameter int ADDR_W      = clog2(ROWS),
  parameter int PROC_CYCLES = ROWS + 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_nblk,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_sop,
  output logic              o_eop,
  output logic              o_chblk,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam int COL_W  = cntWidth(N + 1);
  localparam int PROC_W = cntWidth(PROC_CYCLES - 1);

  phase_e            state_q, state_d;
  logic              first_q, first_d;
  logic [CNT_W-1:0]  blkCnt_q, blkCnt_d;
  logic              chblk_q, chblk_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] wrCnt, rdCnt;
  logic [COL_W-1:0]  colCnt;
  logic [PROC_W-1:0] procCnt;
  logic              wrWrap, rdWrap, colWrap, procWrap;
  logic              lastCol;
  logic              unusedCnt;

  // Row address of incoming words; each wrap is one completed column.
  conv_wrap_cnt #(.WIDTH(ADDR_W), .MAX(ROWS - 1)) uWrCnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q != PH_LOAD),
    .en_i   ((state_q == PH_LOAD) && i_in_valid),
    .cnt_o  (wrCnt),
    .wrap_o (wrWrap)
  );

  // Columns completed in the current round; wraps on the last of N+2.
  conv_wrap_cnt #(.WIDTH(COL_W), .MAX(N + 1)) uColCnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q != PH_LOAD),
    .en_i   (wrWrap),
    .cnt_o  (colCnt),
    .wrap_o (colWrap)
  );

  // Fixed-length PROC phase timer.
  conv_wrap_cnt #(.WIDTH(PROC_W), .MAX(PROC_CYCLES - 1)) uProcCnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q != PH_PROC),
    .en_i   (state_q == PH_PROC),
    .cnt_o  (procCnt),
    .wrap_o (procWrap)
  );

  // Output row address, advancing only on accepted transfers.
  conv_wrap_cnt #(.WIDTH(ADDR_W), .MAX(ROWS - N - 1)) uRdCnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q != PH_OUT),
    .en_i   ((state_q == PH_OUT) && i_out_ready),
    .cnt_o  (rdCnt),
    .wrap_o (rdWrap)
  );

  // Only the wrap flags of these two counters steer the FSM.
  assign unusedCnt = ^{colCnt, procCnt};

  // A first round loads all N+2 columns, later rounds just the one new column.
  assign lastCol = !first_q || colWrap;

  // Next-state logic; chblk and done are single-cycle strobes registered here.
  always_comb begin
    state_d  = state_q;
    first_d  = first_q;
    blkCnt_d = blkCnt_q;
    chblk_d  = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      PH_IDLE: begin
        if (i_start) begin
          state_d  = PH_LOAD;
          blkCnt_d = (i_nblk == '0) ? CNT_W'(1) : i_nblk;
          first_d  = 1'b1;
        end
      end
      PH_LOAD: begin
        if (wrWrap) begin
          if (lastCol) begin
            state_d = PH_PROC;
            first_d = 1'b0;
          end else begin
            chblk_d = 1'b1;
          end
        end
      end
      PH_PROC: begin
        if (procWrap) begin
          state_d = PH_OUT;
        end
      end
      PH_OUT: begin
        if (rdWrap) begin
          blkCnt_d = blkCnt_q - 1'b1;
          if (blkCnt_q == CNT_W'(1)) begin
            state_d = PH_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = PH_LOAD;
            chblk_d = 1'b1;
          end
        end
      end
      default: state_d = PH_IDLE;
    endcase
  end

  // State and strobe registers; reset aborts any round in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= PH_IDLE;
      first_q  <= 1'b0;
      blkCnt_q <= '0;
      chblk_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      blkCnt_q <= blkCnt_d;
      chblk_q  <= chblk_d;
      done_q   <= done_d;
    end
  end

  assign {o_eop, o_sop} = state_q;
  assign o_in_ready     = (state_q == PH_LOAD);
  assign o_out_valid    = (state_q == PH_OUT);
  assign o_busy         = (state_q != PH_IDLE);
  assign o_chblk        = chblk_q;
  assign o_done         = done_q;
  assign o_wr_addr      = wrCnt;
  assign o_rd_addr      = rdCnt;

endmodule

// File: tb/tb_conv_phase_seq.sv
// Scoreboard bench for conv_phase_seq with a small-frame configuration.
module tb_conv_phase_seq;

  localparam int N     = 2;
  localparam int ROWS  = 4;
  localparam int PC    = 8;
  localparam int CNT_W = 16;
  localparam int AW    = 2;

  localparam int EV_CHBLK = 0;
  localparam int EV_PROC  = 1;
  localparam int EV_XFER  = 2;
  localparam int EV_DONE  = 3;

  typedef struct {
    int kind;
    int value;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start;
  logic [CNT_W-1:0] i_nblk;
  logic             i_in_valid;
  logic             o_in_ready;
  logic [AW-1:0]    o_wr_addr;
  logic             o_sop, o_eop, o_chblk;
  logic [AW-1:0]    o_rd_addr;
  logic             o_out_valid;
  logic             i_out_ready;
  logic             o_busy, o_done;

  ev_t expectQ[$];
  int  checks    = 0;
  int  errors    = 0;
  int  doneCount = 0;
  int  validMode = 0;
  bit  stallMode = 0;

  conv_phase_seq #(
    .N(N), .ROWS(ROWS), .ADDR_W(AW), .PROC_CYCLES(PC), .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_nblk      (i_nblk),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .o_wr_addr   (o_wr_addr),
    .o_sop       (o_sop),
    .o_eop       (o_eop),
    .o_chblk     (o_chblk),
    .o_rd_addr   (o_rd_addr),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic expectEvent(input int kind, input int value, input string name);
    ev_t e;
    checks++;
    if (expectQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: got kind=%0d value=%0d, expected no event at %0t", name, kind, value, $time);
    end else begin
      e = expectQ.pop_front();
      if (e.kind != kind || e.value != value) begin
        errors++;
        $display("[TB] FAIL %s: got kind=%0d value=%0d, expected kind=%0d value=%0d at %0t",
                 name, kind, value, e.kind, e.value, $time);
      end
    end
  endtask

  // Input driver: valid pattern per mode, ready random or stalled at OUT start.
  initial begin
    bit gapBit;
    int stallLeft;
    gapBit = 0;
    stallLeft = 0;
    i_in_valid = 0;
    i_out_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      gapBit = !gapBit;
      case (validMode)
        0:       i_in_valid = 1'b1;
        1:       i_in_valid = gapBit;
        default: i_in_valid = ($urandom_range(0, 9) < 7);
      endcase
      if (o_out_valid) begin
        if (stallLeft > 0) begin
          i_out_ready = 1'b0;
          stallLeft--;
        end else begin
          i_out_ready = ($urandom_range(0, 3) != 0);
        end
      end else begin
        stallLeft = stallMode ? 5 : 0;
        i_out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: turns DUT activity into events and checks them against the queue.
  initial begin
    int procLen;
    int wordCnt;
    bit prevChblk;
    logic [1:0] phase;
    procLen = 0;
    wordCnt = 0;
    prevChblk = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        procLen = 0;
        wordCnt = 0;
        prevChblk = 0;
      end else begin
        phase = {o_eop, o_sop};
        if (phase == 2'b01) begin
          procLen++;
        end else begin
          if (procLen > 0 && phase == 2'b10) expectEvent(EV_PROC, procLen, "proc_len");
          procLen = 0;
        end
        if (o_chblk) begin
          checkOutput("chblk_gap", int'(prevChblk), 0);
          checkOutput("chblk_phase", int'(phase), 0);
          expectEvent(EV_CHBLK, wordCnt, "chblk_words");
        end
        prevChblk = o_chblk;
        if (o_out_valid) begin
          checkOutput("ov_phase", int'(phase), 2);
          if (i_out_ready) begin
            expectEvent(EV_XFER, int'(o_rd_addr), "rd_addr");
          end else begin
            checkOutput("stall_pending_kind", (expectQ.size() > 0) ? expectQ[0].kind : -1, EV_XFER);
            if (expectQ.size() > 0) checkOutput("stall_rd_hold", int'(o_rd_addr), expectQ[0].value);
          end
        end
        if (o_done) begin
          doneCount++;
          checkOutput("done_phase", int'(phase), 3);
          checkOutput("done_busy", int'(o_busy), 0);
          expectEvent(EV_DONE, wordCnt, "done_words");
        end
        if (o_in_ready && i_in_valid) begin
          checkOutput("wr_addr", int'(o_wr_addr), wordCnt % ROWS);
          wordCnt++;
        end
        if (!o_busy) wordCnt = 0;
      end
    end
  end

  // Reference model of one run: events keyed by cumulative accepted words.
  task automatic pushRun(input int nblk);
    int eff, base, cols;
    eff = (nblk == 0) ? 1 : nblk;
    base = 0;
    for (int r = 0; r < eff; r++) begin
      cols = (r == 0) ? N + 2 : 1;
      for (int c = 1; c < cols; c++) expectQ.push_back('{EV_CHBLK, base + c * ROWS});
      base += cols * ROWS;
      expectQ.push_back('{EV_PROC, PC});
      for (int k = 0; k < ROWS - N; k++) expectQ.push_back('{EV_XFER, k});
      if (r < eff - 1) expectQ.push_back('{EV_CHBLK, base});
    end
    expectQ.push_back('{EV_DONE, base});
  endtask

  task automatic pulseStart(input int nblk);
    @(posedge clk);
    #1;
    i_start = 1'b1;
    i_nblk = CNT_W'(nblk);
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_nblk = CNT_W'($urandom_range(1, 7));
  endtask

  task automatic applyStimulus(input int nblk, input int vMode, input bit stall, input bit extraStart);
    int startDone, waited;
    validMode = vMode;
    stallMode = stall;
    pushRun(nblk);
    startDone = doneCount;
    pulseStart(nblk);
    if (extraStart) begin
      repeat (2) @(posedge clk);
      pulseStart(5);
    end
    waited = 0;
    while (doneCount == startDone && waited < 3000) begin
      @(posedge clk);
      waited++;
    end
    checkOutput("run_completes", doneCount - startDone, 1);
    repeat (3) @(posedge clk);
    checkOutput("queue_drained", expectQ.size(), 0);
    expectQ.delete();
  endtask

  task automatic resetMidProc();
    int waited;
    validMode = 0;
    stallMode = 0;
    for (int c = 1; c < N + 2; c++) expectQ.push_back('{EV_CHBLK, c * ROWS});
    pulseStart(1);
    waited = 0;
    while ({o_eop, o_sop} != 2'b01 && waited < 500) begin
      @(posedge clk);
      waited++;
    end
    checkOutput("reach_proc", int'({o_eop, o_sop}), 1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkAsIdle("midrst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    checkOutput("midrst_queue", expectQ.size(), 0);
    expectQ.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic checkAsIdle(input string tag);
    checkOutput({tag, "_phase"}, int'({o_eop, o_sop}), 3);
    checkOutput({tag, "_chblk"}, int'(o_chblk), 0);
    checkOutput({tag, "_in_ready"}, int'(o_in_ready), 0);
    checkOutput({tag, "_out_valid"}, int'(o_out_valid), 0);
    checkOutput({tag, "_busy"}, int'(o_busy), 0);
    checkOutput({tag, "_done"}, int'(o_done), 0);
    checkOutput({tag, "_wr_addr"}, int'(o_wr_addr), 0);
    checkOutput({tag, "_rd_addr"}, int'(o_rd_addr), 0);
  endtask

  // Test sequence: reset, directed scenarios, then a few randomised runs.
  initial begin
    rst = 1'b0;
    i_start = 1'b0;
    i_nblk = '0;
    repeat (3) @(posedge clk);
    #1;
    checkAsIdle("reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);

    applyStimulus(1, 0, 0, 0);
    applyStimulus(3, 2, 0, 0);
    applyStimulus(1, 0, 1, 0);
    applyStimulus(2, 1, 0, 0);
    resetMidProc();
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 2, 0, 0);
    applyStimulus(2, 2, 0, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_phase_seq.md
Name: conv_phase_seq

Overview:
- Frame sequencer that drives the phase inputs of the memory-bank controller: the {eop,sop} phase code and the column-change (chblk) pulse.
- It is the initiator side of the same sop/eop/chblk interface that the bank controller responds to.
- Sequences LOAD -> PROC -> OUT rounds for a 2D convolution pass over N+2 column memories.
- Generates the write addresses used while loading and the read addresses used while draining, with a valid/ready handshake on output.

Parameters:
N, 2, kernel size minus one; the bank holds N+2 column memories.
ROWS, 16, words per image column (minimum 4).
ADDR_W, clog2(ROWS), address width.
PROC_CYCLES, ROWS+4, fixed datapath latency of the PROC phase, in clocks (minimum 1).
CNT_W, 16, width of the round-count input.

Ports:
clk  in  1  system clock.
rst  in  1  reset.
i_start  in  1  one-cycle start strobe; honoured only in IDLE.
i_nblk  in  CNT_W  number of rounds; sampled on an accepted i_start; 0 is treated as 1.
i_in_valid  in  1  input word strobe during LOAD; no backpressure.
o_in_ready  out  1  high while in LOAD.
o_wr_addr  out  ADDR_W  row address of the current input word.
o_sop  out  1  phase code bit 0.
o_eop  out  1  phase code bit 1.
o_chblk  out  1  column-change pulse.
o_rd_addr  out  ADDR_W  output row address.
o_out_valid  out  1  output word valid.
i_out_ready  in  1  downstream accepts the output word.
o_busy  out  1  high whenever the block is not in IDLE.
o_done  out  1  one-cycle pulse when the final round completes.

Behaviour:
- Reset: single clock clk; rst is asynchronous, active-low.
- While rst is low: state IDLE, {o_eop,o_sop}=11, o_chblk=0, o_in_ready=0, o_out_valid=0, o_busy=0, o_done=0, all addresses and counters 0.
- Reset asserted mid-operation aborts immediately to these values. The sequencer does not resume the interrupted round.
- Phase codes: LOAD=00, PROC=01, OUT=10, IDLE=11. The bank controller treats 11 as an idle phase with all write enables off.
- All outputs are registered and change only on the clk edge.
- IDLE:
  - i_start -> LOAD on the next cycle.
  - Latch i_nblk into blk_cnt (0 -> 1).
  - Set first=1, col=0, wr_addr=0.
- LOAD:
  - o_in_ready=1.
  - Each cycle with i_in_valid increments wr_addr.
  - A column completes when i_in_valid is high and wr_addr==ROWS-1. wr_addr then wraps to 0 and col increments.
  - Columns required in this round: N+2 if first=1, else 1.
  - On a column completion that is not the last column of the round: o_chblk=1 for exactly the next cycle, then 0.
  - o_chblk is never high for two consecutive cycles. ROWS>=4 guarantees that it is low between pulses.
  - On completion of the last column of the round: go to PROC; o_chblk stays 0; clear first.
  - i_in_valid outside LOAD is ignored.
- PROC:
  - A cycle counter runs from 0 to PROC_CYCLES-1, then the state moves to OUT.
  - Nothing else is driven during PROC; addresses hold 0.
- OUT:
  - o_out_valid=1.
  - A word transfers when o_out_valid && i_out_ready. On each transfer rd_addr increments.
  - The phase ends after ROWS-N transfers, i.e. on the transfer with rd_addr==ROWS-N-1.
  - o_rd_addr holds while i_out_ready is low.
  - On completion: blk_cnt decrements.
    - If blk_cnt was 1: go to IDLE and pulse o_done for one cycle, coincident with the first IDLE cycle.
    - Otherwise: go to LOAD with a 1-column round.
  - Every OUT exit to LOAD asserts o_chblk for the first LOAD cycle. This advances the controller's output and load memory selects.
- Simultaneous events: i_start while busy is ignored. A late i_in_valid on the cycle that LOAD exits is ignored.
- Latencies:
  - i_start -> first LOAD cycle: 1 clock.
  - Last input word -> PROC phase code: 1 clock.
  - PROC phase length: PROC_CYCLES clocks.

Decomposition:
- Shared package conv_pkg holds the phase-code constants LOAD/PROC/OUT/IDLE, the clog2 function, and the default N/ROWS.
- The bank controller and this block both import the package.
- One natural sub-module: conv_wrap_cnt. It is a parameterised modulo counter with enable, wrap flag and synchronous clear. It is instantiated for wr_addr, rd_addr, the PROC cycle counter and the column counter.
- The FSM stays in the top module.

Test Plan:
1. Reset and single round. ROWS=4, N=2, i_nblk=1. Pulse i_start, then 16 consecutive i_in_valid.
   - chblk pulses 3 times, the cycle after words 4, 8 and 12.
   - Phase becomes 01 after word 16 and holds for PROC_CYCLES=8 cycles.
   - Then phase 10; 2 transfers with rd_addr 0,1.
   - o_done pulses once; phase returns to 11.
2. Multi-round, i_nblk=3.
   - The second and third LOAD phases accept exactly 4 words each.
   - chblk is high on the first cycle of each of those LOAD phases.
   - o_done occurs only after the third OUT.
3. Output backpressure: hold i_out_ready=0 for 5 cycles in OUT.
   - o_out_valid stays 1 and o_rd_addr holds at 0.
   - OUT completes 2 transfers after ready returns.
4. Gapped input: i_in_valid asserted every other cycle.
   - wr_addr advances only on valid cycles.
   - chblk timing tracks completed columns, not elapsed cycles.
5. Reset mid-PROC: drop rst for 1 cycle.
   - Outputs immediately go to IDLE values (phase 11, busy 0).
   - A subsequent i_start restarts with an N+2-column LOAD.
6. Edge inputs:
   - i_nblk=0 behaves as 1.
   - i_start during LOAD is ignored; the round count is unchanged.
